// File: rtl/mau_pkg.sv
// Shared encodings and the alignment rule for the MEM-stage load/store unit.
package mau_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    CAP  = 2'd2,
    WR   = 2'd3
  } mauState_t;

  // Size 2'b11 is never a legal access.
  function automatic logic isMisaligned(input logic [1:0] size, input logic [1:0] off);
    case (size)
      SZ_BYTE: return 1'b0;
      SZ_HALF: return off[0];
      SZ_WORD: return off != 2'b00;
      default: return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/byte_lane_unit.sv
// Combinational lane select: extracts/extends a load lane and merges a store lane into a word.
module byte_lane_unit
  import mau_pkg::*;
#(
  parameter bit BIG_ENDIAN = 1'b1
) (
  input  logic [1:0]  size,
  input  logic [1:0]  offset,
  input  logic        signExt,
  input  logic [31:0] memWord,
  input  logic [31:0] storeData,
  output logic [31:0] loadData,
  output logic [31:0] mergedWord
);

  logic [4:0]  shamt;
  logic [31:0] laneMask;
  logic [31:0] shifted;

  always_comb begin
    shamt    = '0;
    laneMask = '1;
    case (size)
      SZ_BYTE: begin
        shamt    = BIG_ENDIAN ? {~offset, 3'b000} : {offset, 3'b000};
        laneMask = 32'h0000_00FF;
      end
      SZ_HALF: begin
        shamt    = BIG_ENDIAN ? {~offset[1], 4'b0000} : {offset[1], 4'b0000};
        laneMask = 32'h0000_FFFF;
      end
      default: ;
    endcase

    shifted = memWord >> shamt;
    case (size)
      SZ_BYTE: loadData = {{24{signExt & shifted[7]}}, shifted[7:0]};
      SZ_HALF: loadData = {{16{signExt & shifted[15]}}, shifted[15:0]};
      default: loadData = shifted;
    endcase

    mergedWord = (memWord & ~(laneMask << shamt)) | ((storeData & laneMask) << shamt);
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage load/store initiator: turns byte/half/word requests into aligned word
// accesses on a Data_Memory port, using read-modify-write for sub-word stores.
module mem_access_unit
  import mau_pkg::*;
#(
  parameter bit BIG_ENDIAN = 1'b1,
  parameter int ADDR_W     = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              mem_write,
  output logic              mem_read,
  input  logic [31:0]       mem_rdata
);

  mauState_t         state, stateN;
  logic              wrL, sgnL;
  logic [1:0]        sizeL, offL;
  logic [31:0]       wdataL;
  logic              accept, misal;
  logic [31:0]       loadData, mergedWord;
  logic              readyN, respValidN, respErrN, memReadN, memWriteN;
  logic [31:0]       respRdataN, memWdataN;
  logic [ADDR_W-1:0] memAddrN;

  byte_lane_unit #(.BIG_ENDIAN(BIG_ENDIAN)) uLane (
    .size      (sizeL),
    .offset    (offL),
    .signExt   (sgnL),
    .memWord   (mem_rdata),
    .storeData (wdataL),
    .loadData  (loadData),
    .mergedWord(mergedWord)
  );

  assign misal  = isMisaligned(req_size, req_addr[1:0]);
  assign accept = req_valid && req_ready;

  always_comb begin
    stateN     = state;
    respValidN = 1'b0;
    respErrN   = 1'b0;
    respRdataN = '0;
    memReadN   = 1'b0;
    memWriteN  = 1'b0;
    memAddrN   = mem_addr;
    memWdataN  = mem_wdata;
    case (state)
      IDLE: if (accept) begin
        if (misal) begin
          respValidN = 1'b1;
          respErrN   = 1'b1;
        end else begin
          memAddrN = {req_addr[ADDR_W-1:2], 2'b00};
          if (req_write && req_size == SZ_WORD) begin
            stateN    = WR;
            memWriteN = 1'b1;
            memWdataN = req_wdata;
          end else begin
            stateN   = RD;
            memReadN = 1'b1;
          end
        end
      end
      RD: begin
        stateN   = CAP;
        memReadN = 1'b1;
      end
      // Sampling at the end of CAP covers both combinational and registered memories.
      CAP: if (wrL) begin
        stateN    = WR;
        memWriteN = 1'b1;
        memWdataN = mergedWord;
      end else begin
        stateN     = IDLE;
        respValidN = 1'b1;
        respRdataN = loadData;
      end
      WR: begin
        stateN     = IDLE;
        respValidN = 1'b1;
      end
      default: stateN = IDLE;
    endcase
    readyN = (stateN == IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      resp_rdata <= '0;
      mem_read   <= 1'b0;
      mem_write  <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
    end else begin
      state      <= stateN;
      req_ready  <= readyN;
      resp_valid <= respValidN;
      resp_err   <= respErrN;
      resp_rdata <= respRdataN;
      mem_read   <= memReadN;
      mem_write  <= memWriteN;
      mem_addr   <= memAddrN;
      mem_wdata  <= memWdataN;
    end
  end

  always_ff @(posedge clk) begin
    if (accept && !misal) begin
      wrL    <= req_write;
      sgnL   <= req_signed;
      sizeL  <= req_size;
      offL   <= req_addr[1:0];
      wdataL <= req_wdata;
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: big- and little-endian instances run in lockstep against
// a byte-addressed reference memory.
module tb_mem_access_unit;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        req_valid, req_write, req_signed;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;

  logic        readyB, rvB, errB, mrB, mwB;
  logic [31:0] rdB, maB, mwdB, mrdB;
  logic        readyL, rvL, errL, mrL, mwL;
  logic [31:0] rdL, maL, mwdL, mrdL;

  logic [31:0] memB [16];
  logic [31:0] memL [16];
  logic        plEn;
  logic [3:0]  plIdx;
  logic [31:0] plData;

  int checks = 0;
  int failures = 0;

  // Reference memory as bytes: [0] big-endian DUT, [1] little-endian DUT
  logic [7:0] refMem [2][64];

  mem_access_unit #(.BIG_ENDIAN(1'b1), .ADDR_W(32)) dutB (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(readyB), .req_write(req_write),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(rvB), .resp_rdata(rdB), .resp_err(errB), .mem_addr(maB), .mem_wdata(mwdB),
    .mem_write(mwB), .mem_read(mrB), .mem_rdata(mrdB));

  mem_access_unit #(.BIG_ENDIAN(1'b0), .ADDR_W(32)) dutL (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(readyL), .req_write(req_write),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(rvL), .resp_rdata(rdL), .resp_err(errL), .mem_addr(maL), .mem_wdata(mwdL),
    .mem_write(mwL), .mem_read(mrL), .mem_rdata(mrdL));

  assign mrdB = memB[maB[5:2]];
  assign mrdL = memL[maL[5:2]];

  always @(posedge clk) begin
    if (plEn) begin
      memB[plIdx] <= plData;
      memL[plIdx] <= plData;
    end
    if (mwB) memB[maB[5:2]] <= mwdB;
    if (mwL) memL[maL[5:2]] <= mwdL;
  end

  function automatic int nBytes(input logic [1:0] sz);
    return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
  endfunction

  function automatic logic [31:0] refLoad(input int e, input int a, input logic [1:0] sz, input logic sgn);
    logic [31:0] v = '0;
    int n = nBytes(sz);
    for (int i = 0; i < n; i++) begin
      if (e == 0) v = (v << 8) | 32'(refMem[0][a+i]);
      else        v = v | (32'(refMem[1][a+i]) << (8*i));
    end
    if (sgn && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8*n));
    return v;
  endfunction

  task automatic refStore(input int a, input logic [1:0] sz, input logic [31:0] wd);
    int n = nBytes(sz);
    for (int i = 0; i < n; i++) begin
      refMem[0][a+i] = wd[8*(n-1-i) +: 8];
      refMem[1][a+i] = wd[8*i +: 8];
    end
  endtask

  task automatic setWord(input logic [31:0] a, input logic [31:0] w);
    plEn = 1'b1; plIdx = a[5:2]; plData = w;
    for (int i = 0; i < 4; i++) begin
      refMem[0][int'({a[5:2], 2'b00}) + i] = w[8*(3-i) +: 8];
      refMem[1][int'({a[5:2], 2'b00}) + i] = w[8*i +: 8];
    end
    @(posedge clk); #1;
    plEn = 1'b0;
  endtask

  // Issues one request to both DUTs and collects what happened; lat=0 means no response.
  task automatic runTxn(input logic w, input logic [1:0] sz, input logic sgn, input logic [31:0] a,
                        input logic [31:0] wd, output int lat, output int nRd, output int nWr,
                        output int waited, output logic [31:0] rB, output logic [31:0] rL,
                        output logic eB, output logic eL, output bit bad);
    lat = 0; nRd = 0; nWr = 0; waited = 0; rB = '0; rL = '0; eB = 1'b0; eL = 1'b0; bad = 1'b0;
    while (!(readyB && readyL) && waited < 20) begin
      @(posedge clk); #1; waited++;
    end
    req_valid = 1'b1; req_write = w; req_size = sz; req_signed = sgn; req_addr = a; req_wdata = wd;
    @(posedge clk); #1;
    req_valid = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      if (mrB) nRd++;
      if (mwB) nWr++;
      if ((mrB && mwB) || ((mrB || mwB) && maB != {a[31:2], 2'b00}) ||
          mrB != mrL || mwB != mwL || rvB != rvL) bad = 1'b1;
      if (rvB) begin
        lat = k; rB = rdB; rL = rdL; eB = errB; eL = errL;
        break;
      end
      @(posedge clk); #1;
    end
  endtask

  int lat, nRd, nWr, waited;
  logic [31:0] rB, rL;
  logic eB, eL;
  bit bad;

  task automatic test_reset();
    rst = 1'b1; req_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({readyB, rvB, errB, mrB, mwB, rdB, maB, mwdB} !== {5'b10000, 96'h0}) begin
      failures++;
      $display("FAIL reset_be got=%b/%h/%h/%h exp=10000/0/0/0", {readyB, rvB, errB, mrB, mwB}, rdB, maB, mwdB);
    end
    checks++;
    if ({readyL, rvL, errL, mrL, mwL, rdL, maL, mwdL} !== {5'b10000, 96'h0}) begin
      failures++;
      $display("FAIL reset_le got=%b/%h/%h/%h exp=10000/0/0/0", {readyL, rvL, errL, mrL, mwL}, rdL, maL, mwdL);
    end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_word_store();
    runTxn(1'b1, 2'd2, 1'b0, 32'h4, 32'h1234_5678, lat, nRd, nWr, waited, rB, rL, eB, eL, bad);
    refStore(4, 2'd2, 32'h1234_5678);
    checks++;
    if (lat != 2 || nWr != 1 || nRd != 0 || eB || bad) begin
      failures++;
      $display("FAIL sw_timing got lat=%0d rd=%0d wr=%0d err=%b bad=%b exp lat=2 rd=0 wr=1 err=0 bad=0", lat, nRd, nWr, eB, bad);
    end
    checks++;
    if (memB[1] !== 32'h1234_5678 || memL[1] !== 32'h1234_5678) begin
      failures++;
      $display("FAIL sw_data got=%h/%h exp=12345678", memB[1], memL[1]);
    end
  endtask

  task automatic test_byte_loads();
    setWord(32'h4, 32'h12F4_5678);
    runTxn(1'b0, 2'd0, 1'b1, 32'h5, 32'h0, lat, nRd, nWr, waited, rB, rL, eB, eL, bad);
    checks++;
    if (lat != 3 || nRd != 2 || nWr != 0 || bad) begin
      failures++;
      $display("FAIL lb_timing got lat=%0d rd=%0d wr=%0d bad=%b exp lat=3 rd=2 wr=0", lat, nRd, nWr, bad);
    end
    checks++;
    if (rB !== 32'hFFFF_FFF4 || rL !== refLoad(1, 5, 2'd0, 1'b1) || eB || eL) begin
      failures++;
      $display("FAIL lb_data got=%h/%h exp=fffffff4/%h", rB, rL, refLoad(1, 5, 2'd0, 1'b1));
    end
    runTxn(1'b0, 2'd0, 1'b0, 32'h5, 32'h0, lat, nRd, nWr, waited, rB, rL, eB, eL, bad);
    checks++;
    if (rB !== 32'h0000_00F4 || rL !== refLoad(1, 5, 2'd0, 1'b0) || lat != 3) begin
      failures++;
      $display("FAIL lbu_data got=%h/%h lat=%0d exp=000000f4/%h lat=3", rB, rL, lat, refLoad(1, 5, 2'd0, 1'b0));
    end
  endtask

  task automatic test_half_rmw();
    setWord(32'h4, 32'h1234_5678);
    runTxn(1'b1, 2'd1, 1'b0, 32'h6, 32'h0000_ABCD, lat, nRd, nWr, waited, rB, rL, eB, eL, bad);
    refStore(6, 2'd1, 32'h0000_ABCD);
    checks++;
    if (lat != 4 || nRd != 2 || nWr != 1 || bad || rB !== 32'h0) begin
      failures++;
      $display("FAIL sh_timing got lat=%0d rd=%0d wr=%0d bad=%b exp lat=4 rd=2 wr=1", lat, nRd, nWr, bad);
    end
    checks++;
    if (memB[1] !== 32'h1234_ABCD || memL[1] !== refLoad(1, 4, 2'd2, 1'b0)) begin
      failures++;
      $display("FAIL sh_merge got=%h/%h exp=1234abcd/%h", memB[1], memL[1], refLoad(1, 4, 2'd2, 1'b0));
    end
    runTxn(1'b0, 2'd1, 1'b1, 32'h6, 32'h0, lat, nRd, nWr, waited, rB, rL, eB, eL, bad);
    checks++;
    if (rB !== 32'hFFFF_ABCD || rL !== refLoad(1, 6, 2'd1, 1'b1)) begin
      failures++;
      $display("FAIL lh_data got=%h/%h exp=ffffabcd/%h", rB, rL, refLoad(1, 6, 2'd1, 1'b1));
    end
  endtask

  task automatic test_misaligned();
    runTxn(1'b0, 2'd2, 1'b0, 32'h2, 32'h0, lat, nRd, nWr, waited, rB, rL, eB, eL, bad);
    checks++;
    if (lat != 1 || nRd != 0 || nWr != 0 || !eB || !eL || rB !== 32'h0 || rL !== 32'h0) begin
      failures++;
      $display("FAIL misaligned got lat=%0d rd=%0d wr=%0d err=%b%b data=%h exp lat=1 rd=0 wr=0 err=11 data=0",
               lat, nRd, nWr, eB, eL, rB);
    end
  endtask

  task automatic test_back_to_back();
    setWord(32'h8, 32'h0);
    runTxn(1'b1, 2'd0, 1'b0, 32'h8, 32'h0000_00AA, lat, nRd, nWr, waited, rB, rL, eB, eL, bad);
    refStore(8, 2'd0, 32'h0000_00AA);
    checks++;
    if (lat != 4 || !(readyB && readyL)) begin
      failures++;
      $display("FAIL b2b_sb got lat=%0d ready=%b%b exp lat=4 ready=11", lat, readyB, readyL);
    end
    runTxn(1'b0, 2'd2, 1'b0, 32'h8, 32'h0, lat, nRd, nWr, waited, rB, rL, eB, eL, bad);
    checks++;
    if (waited != 0 || lat != 3 || rB !== 32'hAA00_0000 || rL !== 32'h0000_00AA) begin
      failures++;
      $display("FAIL b2b_lw got wait=%0d lat=%0d data=%h/%h exp wait=0 lat=3 data=aa000000/000000aa",
               waited, lat, rB, rL);
    end
  endtask

  task automatic test_reset_mid_rmw();
    bit seen = 1'b0;
    setWord(32'h4, 32'h1234_5678);
    req_valid = 1'b1; req_write = 1'b1; req_size = 2'd1; req_signed = 1'b0;
    req_addr = 32'h6; req_wdata = 32'h0000_ABCD;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++;
    if (mrB || mwB || mrL || mwL || rvB || rvL || !readyB || !readyL) begin
      failures++;
      $display("FAIL rst_abort got rd=%b%b wr=%b%b rv=%b%b ready=%b%b exp rd=00 wr=00 rv=00 ready=11",
               mrB, mrL, mwB, mwL, rvB, rvL, readyB, readyL);
    end
    repeat (6) begin
      @(posedge clk); #1;
      if (mwB || mwL || rvB || rvL) seen = 1'b1;
    end
    checks++;
    if (seen || memB[1] !== 32'h1234_5678 || memL[1] !== 32'h1234_5678) begin
      failures++;
      $display("FAIL rst_nowrite got seen=%b mem=%h/%h exp seen=0 mem=12345678", seen, memB[1], memL[1]);
    end
  endtask

  task automatic test_random();
    logic w, sgn, misal;
    logic [1:0] sz;
    logic [31:0] a, wd, expB, expL;
    int n, expLat, expRd, expWr;
    for (int i = 0; i < 16; i++) setWord(32'(i * 4), $urandom);
    for (int t = 0; t < 80; t++) begin
      w   = 1'($urandom_range(0, 1));
      sgn = 1'($urandom_range(0, 1));
      n   = $urandom_range(0, 9);
      sz  = (n == 9) ? 2'd3 : 2'(n % 3);
      a   = 32'($urandom_range(0, 63));
      if ($urandom_range(0, 3) != 0) a = a & ~32'(nBytes(sz) - 1);
      wd  = $urandom;
      n   = nBytes(sz);
      misal  = (sz == 2'd3) || (int'(a) % n != 0);
      expLat = misal ? 1 : !w ? 3 : (n == 4) ? 2 : 4;
      expRd  = (misal || (w && n == 4)) ? 0 : 2;
      expWr  = (!misal && w) ? 1 : 0;
      expB   = (misal || w) ? 32'h0 : refLoad(0, int'(a), sz, sgn);
      expL   = (misal || w) ? 32'h0 : refLoad(1, int'(a), sz, sgn);
      runTxn(w, sz, sgn, a, wd, lat, nRd, nWr, waited, rB, rL, eB, eL, bad);
      checks++;
      if (lat != expLat || nRd != expRd || nWr != expWr || bad || eB !== misal || eL !== misal ||
          rB !== expB || rL !== expL) begin
        failures++;
        $display("FAIL rand_%0d w=%b sz=%0d a=%h got lat=%0d rd=%0d wr=%0d bad=%b err=%b%b data=%h/%h exp lat=%0d rd=%0d wr=%0d err=%b data=%h/%h",
                 t, w, sz, a, lat, nRd, nWr, bad, eB, eL, rB, rL, expLat, expRd, expWr, misal, expB, expL);
      end
      if (w && !misal) begin
        refStore(int'(a), sz, wd);
        checks++;
        if (memB[a[5:2]] !== refLoad(0, int'({a[31:2], 2'b00}), 2'd2, 1'b0) ||
            memL[a[5:2]] !== refLoad(1, int'({a[31:2], 2'b00}), 2'd2, 1'b0)) begin
          failures++;
          $display("FAIL rand_mem_%0d a=%h got=%h/%h exp=%h/%h", t, a, memB[a[5:2]], memL[a[5:2]],
                   refLoad(0, int'({a[31:2], 2'b00}), 2'd2, 1'b0), refLoad(1, int'({a[31:2], 2'b00}), 2'd2, 1'b0));
        end
      end
    end
  endtask

  initial begin
    rst = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_size = 2'd0; req_signed = 1'b0;
    req_addr = '0; req_wdata = '0; plEn = 1'b0; plIdx = '0; plData = '0;
    for (int e = 0; e < 2; e++)
      for (int i = 0; i < 64; i++) refMem[e][i] = 8'h00;
    test_reset();
    test_word_store();
    test_byte_loads();
    test_half_rmw();
    test_misaligned();
    test_back_to_back();
    test_reset_mid_rmw();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
